// File: rtl/breadboard_button_reader.sv
// Debounced FLAP/START pushbutton reader: 2-flop sync, per-button debounce FSM, press pulses,
// debounced levels and a saturating FLAP press counter. Optional FLAP auto-repeat: BB_AUTOREPEAT_EN.
module breadboard_button_reader #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 15000000,
    parameter int unsigned REPEAT_PERIOD   = 6250000
) (
    input  logic        clk,
    input  logic        KEY0,
    input  logic [1:0]  ARDUINO_IN,
    output logic        flap_pulse,
    output logic        start_pulse,
    output logic        flap_level,
    output logic        start_level,
    output logic [15:0] flap_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        PRESSED   = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    logic [1:0] sync1_r;
    logic [1:0] sync2_r;
    logic [1:0] accept_s;
    logic [1:0] level_s;
    logic [1:0] hold_run_s;
    logic       repeat_s;

    // input synchronizers, stored inverted so 1 = pressed
    always_ff @(posedge clk or negedge KEY0) begin
        if (!KEY0) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= ~ARDUINO_IN;
            sync2_r <= sync1_r;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_btn
        state_t      state_r;
        state_t      state_nxt_s;
        logic [31:0] cnt_r;
        logic [31:0] cnt_nxt_s;
        logic        level_r;
        logic        level_nxt_s;
        logic        accept_btn_s;

        // debounce state, counter and level registers
        always_ff @(posedge clk or negedge KEY0) begin
            if (!KEY0) begin
                state_r <= IDLE;
                cnt_r   <= 32'd0;
                level_r <= 1'b0;
            end else begin
                state_r <= state_nxt_s;
                cnt_r   <= cnt_nxt_s;
                level_r <= level_nxt_s;
            end
        end

        // next-state and accept-window counter
        always_comb begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
            case (state_r)
                IDLE: begin
                    if (sync2_r[b]) begin
                        state_nxt_s = PRESS_CHK;
                        cnt_nxt_s   = 32'd0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                PRESS_CHK: begin
                    if (!sync2_r[b]) begin
                        state_nxt_s = IDLE;
                    end else if (cnt_r == DEBOUNCE_CYCLES - 32'd1) begin
                        state_nxt_s = PRESSED;
                    end else begin
                        cnt_nxt_s = cnt_r + 32'd1;
                    end
                end
                PRESSED: begin
                    if (!sync2_r[b]) begin
                        state_nxt_s = REL_CHK;
                        cnt_nxt_s   = 32'd0;
                    end else begin
                        state_nxt_s = PRESSED;
                    end
                end
                REL_CHK: begin
                    if (sync2_r[b]) begin
                        state_nxt_s = PRESSED;
                    end else if (cnt_r == DEBOUNCE_CYCLES - 32'd1) begin
                        state_nxt_s = IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r + 32'd1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 32'd0;
                end
            endcase
        end

        // level update and press acceptance
        always_comb begin
            level_nxt_s  = level_r;
            accept_btn_s = 1'b0;
            case (state_r)
                PRESS_CHK: begin
                    if (sync2_r[b] && (cnt_r == DEBOUNCE_CYCLES - 32'd1)) begin
                        level_nxt_s  = 1'b1;
                        accept_btn_s = 1'b1;
                    end else begin
                        level_nxt_s = level_r;
                    end
                end
                REL_CHK: begin
                    if (!sync2_r[b] && (cnt_r == DEBOUNCE_CYCLES - 32'd1)) begin
                        level_nxt_s = 1'b0;
                    end else begin
                        level_nxt_s = level_r;
                    end
                end
                default: begin
                    level_nxt_s = level_r;
                end
            endcase
        end

        assign accept_s[b]   = accept_btn_s;
        assign level_s[b]    = level_r;
        assign hold_run_s[b] = (state_r == PRESSED) && sync2_r[b];
    end

`ifdef BB_AUTOREPEAT_EN
    logic [31:0] hold_r;

    // FLAP hold timer; after the first repeat it rewinds so later repeats are REPEAT_PERIOD apart
    always_ff @(posedge clk or negedge KEY0) begin
        if (!KEY0) begin
            hold_r <= 32'd0;
        end else if (accept_s[0]) begin
            hold_r <= 32'd0;
        end else if (hold_run_s[0]) begin
            if (hold_r == REPEAT_DELAY - 32'd1) begin
                hold_r <= REPEAT_DELAY - REPEAT_PERIOD;
            end else begin
                hold_r <= hold_r + 32'd1;
            end
        end else begin
            hold_r <= hold_r;
        end
    end

    assign repeat_s = hold_run_s[0] && (hold_r == REPEAT_DELAY - 32'd1);
`else
    assign repeat_s = 1'b0;
`endif

    // registered pulses and saturating FLAP press counter
    always_ff @(posedge clk or negedge KEY0) begin
        if (!KEY0) begin
            flap_pulse  <= 1'b0;
            start_pulse <= 1'b0;
            flap_count  <= 16'd0;
        end else begin
            flap_pulse  <= accept_s[0] | repeat_s;
            start_pulse <= accept_s[1];
            if (accept_s[0] && (flap_count != 16'hFFFF)) begin
                flap_count <= flap_count + 16'd1;
            end else begin
                flap_count <= flap_count;
            end
        end
    end

    assign flap_level  = level_s[0];
    assign start_level = level_s[1];

endmodule

// File: tb/tb_breadboard_button_reader.sv
// Randomised and directed bench for breadboard_button_reader, scored against a stability-run
// reference model (an input must differ from the accepted level for DEBOUNCE+1 samples to flip it).
module tb_breadboard_button_reader;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic        clk = 1'b0;
    logic        KEY0 = 1'b0;
    logic [1:0]  ARDUINO_IN = 2'b11;
    logic        flap_pulse, start_pulse, flap_level, start_level;
    logic [15:0] flap_count;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [1:0]  m_h1 = 2'b00, m_h2 = 2'b00;
    int          m_run [2] = '{0, 0};
    logic [1:0]  m_level = 2'b00, m_pulse = 2'b00;
    logic [15:0] m_count = 16'd0;
    int          m_hold = 0;

    breadboard_button_reader #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .KEY0       (KEY0),
        .ARDUINO_IN (ARDUINO_IN),
        .flap_pulse (flap_pulse),
        .start_pulse(start_pulse),
        .flap_level (flap_level),
        .start_level(start_level),
        .flap_count (flap_count)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        logic [1:0] s;
        int prev_run;
        logic prev_level;
        if (KEY0 === 1'b0) begin
            m_h1 = 2'b00; m_h2 = 2'b00; m_run = '{0, 0};
            m_level = 2'b00; m_pulse = 2'b00; m_count = 16'd0; m_hold = 0;
        end else begin
            s = m_h2;
            m_h2 = m_h1;
            m_h1 = ~ARDUINO_IN;
            m_pulse = 2'b00;
            for (int b = 0; b < 2; b++) begin
                prev_run = m_run[b];
                prev_level = m_level[b];
                if (s[b] != m_level[b]) m_run[b]++;
                else m_run[b] = 0;
                if (m_run[b] == D + 1) begin
                    m_level[b] = ~m_level[b];
                    m_run[b] = 0;
                    if (m_level[b]) begin
                        m_pulse[b] = 1'b1;
                        if (b == 0) begin
                            m_hold = 0;
                            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                        end
                    end
                end else if (b == 0 && prev_level && prev_run == 0 && s[0]) begin
`ifdef BB_AUTOREPEAT_EN
                    m_hold++;
                    if (m_hold == RD || (m_hold > RD && (m_hold - RD) % RP == 0)) m_pulse[0] = 1'b1;
`endif
                end
            end
        end
    endtask

    // one clock: drive pins (1 = pressed) at the falling edge, advance model, return at next falling edge
    task automatic step(input logic f, input logic st);
        ARDUINO_IN = ~{st, f};
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        KEY0 = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        KEY0 = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        repeat (2) step(1'b0, 1'b0);
        checks++;
        if ({flap_pulse, start_pulse, flap_level, start_level} !== 4'b0000 || flap_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got p=%b%b l=%b%b cnt=%h, expected all zero",
                     flap_pulse, start_pulse, flap_level, start_level, flap_count);
        end
        KEY0 = 1'b1;
    endtask

    task automatic test_clean_press();
        int pulses = 0, first = -1, exp_pulses;
        apply_reset();
        for (int i = 1; i <= 30; i++) begin
            step(i <= 20, 1'b0);
            if (flap_pulse === 1'b1) begin pulses++; if (first < 0) first = i; end
            checks++;
            if (flap_pulse !== m_pulse[0] || flap_level !== m_level[0] || flap_count !== m_count) begin
                errors++;
                $display("FAIL clean_press cycle %0d: got p=%b l=%b cnt=%h, expected p=%b l=%b cnt=%h",
                         i, flap_pulse, flap_level, flap_count, m_pulse[0], m_level[0], m_count);
            end
            if (i == 20) begin
                checks++;
                if (flap_level !== 1'b1) begin
                    errors++;
                    $display("FAIL clean_press_level: got %b, expected 1", flap_level);
                end
            end
        end
`ifdef BB_AUTOREPEAT_EN
        exp_pulses = 3;
`else
        exp_pulses = 1;
`endif
        checks++;
        if (pulses != exp_pulses || first < D + 1 || first > D + 3) begin
            errors++;
            $display("FAIL clean_press_pulses: got %0d pulses first at %0d, expected %0d first in %0d..%0d",
                     pulses, first, exp_pulses, D + 1, D + 3);
        end
        checks++;
        if (flap_count !== 16'd1 || flap_level !== 1'b0) begin
            errors++;
            $display("FAIL clean_press_count: got cnt=%h l=%b, expected cnt=0001 l=0", flap_count, flap_level);
        end
    endtask

    task automatic test_bounce();
        logic pat [10];
        int pulses = 0, lvl = 0;
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            step((i < 10) ? pat[i] : 1'b0, 1'b0);
            if (flap_pulse === 1'b1) pulses++;
            if (flap_level === 1'b1) lvl++;
        end
        checks++;
        if (pulses != 0 || lvl != 0 || flap_count !== 16'd0) begin
            errors++;
            $display("FAIL bounce: got pulses=%0d level_cycles=%0d cnt=%h, expected 0 0 0000",
                     pulses, lvl, flap_count);
        end
    endtask

    task automatic test_simultaneous();
        int fp = -1, sp = -1, fl = -1, sl = -1;
        apply_reset();
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b1);
            if (flap_pulse === 1'b1 && fp < 0) fp = i;
            if (start_pulse === 1'b1 && sp < 0) sp = i;
            if (flap_level === 1'b1 && fl < 0) fl = i;
            if (start_level === 1'b1 && sl < 0) sl = i;
        end
        checks++;
        if (fp < 0 || fp != sp || fl != fp || sl != fp) begin
            errors++;
            $display("FAIL simultaneous: got flap_pulse@%0d start_pulse@%0d flap_level@%0d start_level@%0d, expected all equal",
                     fp, sp, fl, sl);
        end
        repeat (10) step(1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        apply_reset();
        force dut.flap_count = 16'hFFFE;
        step(1'b0, 1'b0);
        release dut.flap_count;
        m_count = 16'hFFFE;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 16; i++) begin
                step(i < 8, 1'b0);
                checks++;
                if (flap_pulse !== m_pulse[0] || flap_level !== m_level[0] || flap_count !== m_count) begin
                    errors++;
                    $display("FAIL saturation press %0d cycle %0d: got p=%b l=%b cnt=%h, expected p=%b l=%b cnt=%h",
                             p, i, flap_pulse, flap_level, flap_count, m_pulse[0], m_level[0], m_count);
                end
            end
        end
        checks++;
        if (flap_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturation_final: got %h, expected FFFF", flap_count);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0, first = -1;
        apply_reset();
        repeat (4) step(1'b1, 1'b0);
        KEY0 = 1'b0;
        #1;
        checks++;
        if ({flap_pulse, start_pulse, flap_level, start_level} !== 4'b0000 || flap_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got p=%b%b l=%b%b cnt=%h, expected all zero",
                     flap_pulse, start_pulse, flap_level, start_level, flap_count);
        end
        @(negedge clk);
        repeat (2) step(1'b1, 1'b0);
        checks++;
        if ({flap_pulse, flap_level} !== 2'b00 || flap_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_held: got p=%b l=%b cnt=%h, expected 0 0 0000", flap_pulse, flap_level, flap_count);
        end
        KEY0 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0);
            if (flap_pulse === 1'b1) begin pulses++; if (first < 0) first = i; end
        end
        checks++;
        if (pulses != 1 || first < D + 1 || first > D + 3 || flap_count !== 16'd1) begin
            errors++;
            $display("FAIL reset_mid_repress: got %0d pulses first at %0d cnt=%h, expected 1 in %0d..%0d cnt=0001",
                     pulses, first, flap_count, D + 1, D + 3);
        end
        repeat (10) step(1'b0, 1'b0);
    endtask

    task automatic test_autorepeat();
        int pulses = 0, exp_pulses;
        apply_reset();
        for (int i = 1; i <= 40; i++) begin
            step(i <= 30, 1'b0);
            if (flap_pulse === 1'b1) pulses++;
            checks++;
            if (flap_pulse !== m_pulse[0] || flap_level !== m_level[0] || flap_count !== m_count) begin
                errors++;
                $display("FAIL autorepeat cycle %0d: got p=%b l=%b cnt=%h, expected p=%b l=%b cnt=%h",
                         i, flap_pulse, flap_level, flap_count, m_pulse[0], m_level[0], m_count);
            end
        end
`ifdef BB_AUTOREPEAT_EN
        exp_pulses = 7;
`else
        exp_pulses = 1;
`endif
        checks++;
        if (pulses != exp_pulses || flap_count !== 16'd1) begin
            errors++;
            $display("FAIL autorepeat_total: got %0d pulses cnt=%h, expected %0d cnt=0001",
                     pulses, flap_count, exp_pulses);
        end
    endtask

    task automatic test_random();
        logic [1:0] cur = 2'b00;
        int rem [2] = '{1, 1};
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 2; b++) begin
                rem[b]--;
                if (rem[b] <= 0) begin
                    cur[b] = ~cur[b];
                    rem[b] = ($urandom_range(0, 2) == 0) ? $urandom_range(D + 2, 16) : $urandom_range(1, D + 1);
                end
            end
            if ($urandom_range(0, 299) == 0) KEY0 = 1'b0;
            else KEY0 = 1'b1;
            step(cur[0], cur[1]);
            checks++;
            if (flap_pulse !== m_pulse[0] || start_pulse !== m_pulse[1] || flap_level !== m_level[0] ||
                start_level !== m_level[1] || flap_count !== m_count) begin
                errors++;
                $display("FAIL random cycle %0d: got p=%b%b l=%b%b cnt=%h, expected p=%b%b l=%b%b cnt=%h",
                         i, flap_pulse, start_pulse, flap_level, start_level, flap_count,
                         m_pulse[0], m_pulse[1], m_level[0], m_level[1], m_count);
            end
        end
        KEY0 = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_saturation();
        test_reset_mid();
        test_autorepeat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
